matmul_index_sequencer: RTL
===========================

# matmul_index_sequencer

Generates the (row, col, k) loop indices and operand addresses that drive the MAC datapath of the matrix multiplication accelerator, for C[M×N] = A[M×K] · B[K×N]. The block sits between the host-facing control logic and the operand memories/MAC array, and issues one index beat per cycle under a valid/ready handshake. It flags the first and last k of each dot product so the accumulator can be cleared and committed. It pulses `done` when the whole product has been issued.

## Interface

Parameters:
- `IDX_W`, 4, width of each index and dimension; dimensions 1..2^IDX_W-1.
- `ADDR_W`, 2*IDX_W, operand address width.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `start`  in  1  request a new product; sampled only in IDLE.
- `m_dim`  in  IDX_W  rows of A/C; sampled with `start`.
- `n_dim`  in  IDX_W  columns of B/C; sampled with `start`.
- `k_dim`  in  IDX_W  inner dimension; sampled with `start`.
- `busy`  out  1  high in RUN.
- `out_valid`  out  1  index beat valid.
- `out_ready`  in  1  consumer accepts beat.
- `row`  out  IDX_W  current i.
- `col`  out  IDX_W  current j.
- `kidx`  out  IDX_W  current k.
- `a_addr`  out  ADDR_W  {row, kidx}.
- `b_addr`  out  ADDR_W  {kidx, col}.
- `first_k`  out  1  kidx==0 (accumulator clear).
- `last_k`  out  1  kidx==K-1 (accumulator commit).
- `done`  out  1  one-cycle pulse after last accepted beat.
- `err`  out  1  one-cycle pulse: start with any zero dimension.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: `start`=1 with all dims nonzero → latch M,N,K, clear i/j/k, go RUN. `start` with any dim zero → stay IDLE, pulse `err` next cycle. Otherwise hold.
- RUN: `out_valid`=1. On `out_valid && out_ready`: k advances; k wraps to 0 at K-1 and carries into j; j wraps at N-1 and carries into i; the beat with i=M-1, j=N-1, k=K-1 → DONE. No handshake → all outputs hold stable.
- DONE: `done`=1, `out_valid`=0, next cycle → IDLE.
- Loop order is k innermost, then j, then i. Total beats = M·N·K.
- `start` in RUN/DONE is ignored. Dimension input changes after sampling have no effect.
- Addresses are pure concatenation with fixed stride 2^IDX_W. No multipliers.
- `first_k`/`last_k` are derived from registered kidx and latched K. For K=1 both are high on every beat.

## Timing

- All outputs registered. Reset values: `busy`, `out_valid`, `done`, `err`, `first_k`, `last_k` = 0. `row`, `col`, `kidx`, `a_addr`, `b_addr` = 0. State = IDLE.
- `start` accepted at edge t → `busy`=`out_valid`=1 with indices (0,0,0) from t+1.
- Throughput: one beat per cycle while `out_ready`=1.
- Last handshake at edge t → `done` high in cycle t+1, `busy`=0 from t+1. IDLE (start accepted) from t+2.
- `clr` at any point, including mid-RUN or in DONE → next cycle in IDLE with reset values. No `done` pulse, no partial beat.
- `err` is high in the cycle after the rejected `start`.

## Structure

- Shared package `matmul_pkg`: `IDX_W` default, `state_t` enum {IDLE, RUN, DONE}.
- Sub-module `idx_counter`, instantiated three times (k, j, i):
  - Ports: `clk`, `clr`, `load0`, `en`, `limit`, `count`, `wrap`.
  - Increments on `en`; returns to 0 with `wrap`=1 when `count==limit-1`.
  - Chain: k.wrap gates j.en; j.wrap gates i.en.
- FSM and output registers live in the top.

## Test plan

- M=N=K=2, `out_ready`=1: start at cycle 0 → 8 beats cycles 1–8, (i,j,k) = 000,001,010,011,100,101,110,111; `first_k` on beats 1,3,5,7; `done` at cycle 9.
- M=1,N=1,K=3, `out_ready` toggling 1,0,1,0…: beats are not lost or duplicated; indices hold during ready=0; `a_addr`=0x00,0x01,0x02; `b_addr`=0x00,0x10,0x20; `last_k` on the third beat only.
- M=N=K=1: a single beat with `first_k`=`last_k`=1, followed by `done`.
- `start` with k_dim=0 → `err` pulse next cycle; `busy` and `out_valid` stay 0; a following valid `start` runs normally.
- M=N=K=15: 3375 beats; final beat has `a_addr`=0xEE and `b_addr`=0xEE; `done` follows once; `start` asserted mid-run is ignored.
- `clr` asserted mid-run at beat 5 of a 2×2×2 product → outputs are 0 the next cycle, no `done`; a fresh `start` restarts from (0,0,0).

Source files
------------

// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared types and constants for the matmul index sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam int c_idx_w = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/matmul_index_sequencer_idx_counter.sv
`default_nettype none
// ============================================================================
// Module      : idx_counter
// Description : Modulo-limit loop counter with wrap flag for carry chaining.
// Revision    : 1.0 - initial release
// ============================================================================
module idx_counter #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load0,
    input  logic             en,
    input  logic [IDX_W-1:0] limit,
    output logic [IDX_W-1:0] count,
    output logic             wrap
);

    localparam logic [IDX_W-1:0] c_one = {{(IDX_W-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == (limit - c_one));
    // wrap is qualified by en so it can directly enable the next loop level
    assign wrap   = en & w_last;
    assign count  = r_count;

    always_ff @(posedge clk) begin
        if (clr || load0) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_last ? '0 : (r_count + c_one);
        end
    end

endmodule : idx_counter
`default_nettype wire

// File: rtl/matmul_index_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : matmul_index_sequencer
// Description : Issues (row, col, k) beats and operand addresses for C = A*B.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_index_sequencer
    import matmul_pkg::*;
#(
    parameter int IDX_W  = c_idx_w,
    parameter int ADDR_W = 2 * IDX_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [IDX_W-1:0]  m_dim,
    input  logic [IDX_W-1:0]  n_dim,
    input  logic [IDX_W-1:0]  k_dim,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  row,
    output logic [IDX_W-1:0]  col,
    output logic [IDX_W-1:0]  kidx,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              first_k,
    output logic              last_k,
    output logic              done,
    output logic              err
);

    localparam logic [IDX_W-1:0] c_one = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [IDX_W-1:0] r_m, r_n, r_k;
    logic             r_busy, r_valid, r_done, r_err, r_first_k, r_last_k;

    logic             w_dims_ok, w_start_ok, w_start_bad, w_hs;
    logic             w_k_wrap, w_j_wrap, w_i_wrap;
    logic [IDX_W-1:0] w_k_cnt, w_j_cnt, w_i_cnt, w_k_next;

    assign w_dims_ok   = (m_dim != '0) && (n_dim != '0) && (k_dim != '0);
    assign w_start_ok  = (r_state == IDLE) && start && w_dims_ok;
    assign w_start_bad = (r_state == IDLE) && start && !w_dims_ok;
    assign w_hs        = r_valid && out_ready;

    // k is innermost; each level only advances when the level below wraps
    idx_counter #(.IDX_W(IDX_W)) u_k_cnt (
        .clk   (clk),
        .clr   (clr),
        .load0 (w_start_ok),
        .en    (w_hs),
        .limit (r_k),
        .count (w_k_cnt),
        .wrap  (w_k_wrap)
    );

    idx_counter #(.IDX_W(IDX_W)) u_j_cnt (
        .clk   (clk),
        .clr   (clr),
        .load0 (w_start_ok),
        .en    (w_k_wrap),
        .limit (r_n),
        .count (w_j_cnt),
        .wrap  (w_j_wrap)
    );

    idx_counter #(.IDX_W(IDX_W)) u_i_cnt (
        .clk   (clk),
        .clr   (clr),
        .load0 (w_start_ok),
        .en    (w_j_wrap),
        .limit (r_m),
        .count (w_i_cnt),
        .wrap  (w_i_wrap)
    );

    // Look-ahead of the k counter so first_k/last_k land with the new index
    assign w_k_next = w_k_wrap ? '0 : (w_k_cnt + c_one);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_n       <= '0;
            r_k       <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_first_k <= 1'b0;
            r_last_k  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_m       <= m_dim;
                        r_n       <= n_dim;
                        r_k       <= k_dim;
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                        r_valid   <= 1'b1;
                        r_first_k <= 1'b1;
                        r_last_k  <= (k_dim == c_one);
                    end else if (w_start_bad) begin
                        r_err <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        if (w_i_wrap) begin
                            r_state   <= DONE;
                            r_busy    <= 1'b0;
                            r_valid   <= 1'b0;
                            r_done    <= 1'b1;
                            r_first_k <= 1'b0;
                            r_last_k  <= 1'b0;
                        end else begin
                            r_first_k <= w_k_wrap;
                            r_last_k  <= (w_k_next == (r_k - c_one));
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign done      = r_done;
    assign err       = r_err;
    assign first_k   = r_first_k;
    assign last_k    = r_last_k;
    assign row       = w_i_cnt;
    assign col       = w_j_cnt;
    assign kidx      = w_k_cnt;
    assign a_addr    = {w_i_cnt, w_k_cnt};
    assign b_addr    = {w_k_cnt, w_j_cnt};

endmodule : matmul_index_sequencer
`default_nettype wire
